// File: rtl/man_tx_frame.sv
// Manchester frame transmitter: latches {payload, parity, stop} on a valid/ready handshake,
// shifts it out MSB first as half-bits on a single clock with an internal divider, then pauses.
module man_tx_frame #(
    parameter int unsigned PAYLOAD_W       = 12,
    parameter int unsigned HALF_BIT_CYCLES = 150,
    parameter int unsigned PAUSE_BITS      = 3,
    parameter bit          PARITY_ODD      = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [PAYLOAD_W-1:0] tx_data,
    input  logic                 tx_abort,
    output logic                 tx_ready,
    output logic                 code,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned N         = PAYLOAD_W + 2;
    localparam int unsigned HB        = 2 * N;
    localparam int unsigned DIV_W     = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam int unsigned HB_W      = $clog2(HB);
    localparam int unsigned PAUSE_CYC = 2 * PAUSE_BITS * HALF_BIT_CYCLES;
    localparam int unsigned PAUSE_W   = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(HALF_BIT_CYCLES - 1);
    localparam logic [HB_W-1:0]    HB_LAST    = HB_W'(HB - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'((PAUSE_CYC > 0) ? PAUSE_CYC - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [HB-1:0]      sr_q, sr_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [HB_W-1:0]    hcnt_q, hcnt_d;
    logic [PAUSE_W-1:0] pcnt_q, pcnt_d;
    logic               code_q, code_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [N-1:0]  word;
    logic [HB-1:0] enc;

    // Each word bit b becomes half-bits {~b, b}, first half in the higher position.
    always_comb begin
        word = {tx_data, (^tx_data) ^ PARITY_ODD, 1'b1};
        enc  = '0;
        for (int i = 0; i < int'(N); i++) begin
            enc[2*i+1] = ~word[i];
            enc[2*i]   = word[i];
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        code_d  = 1'b1;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_SEND;
                    sr_d    = enc;
                    div_d   = '0;
                    hcnt_d  = '0;
                    code_d  = enc[HB-1];
                end
            end
            ST_SEND: begin
                code_d = sr_q[HB-1];
                if (tx_abort || (div_q == DIV_LAST && hcnt_q == HB_LAST)) begin
                    // Abort wins over a coincident frame completion.
                    code_d  = 1'b1;
                    done_d  = ~tx_abort;
                    pcnt_d  = '0;
                    state_d = (PAUSE_BITS == 0) ? ST_IDLE : ST_PAUSE;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    hcnt_d = hcnt_q + 1'b1;
                    sr_d   = {sr_q[HB-2:0], 1'b0};
                    code_d = sr_q[HB-2];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (pcnt_q == PAUSE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            div_q   <= '0;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            code_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            code_q  <= code_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign code       = code_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_man_tx_frame.sv
// Bench for man_tx_frame: three configurations checked cycle by cycle against a
// waveform model derived from frame length, half-bit time and pause length.
module tb_man_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] valid, abort, ready, code, busy, done;
    logic [11:0] data [3];

    int nvec = 0;
    int nerr = 0;

    initial forever #5 clk = ~clk;

    man_tx_frame #(.PAYLOAD_W(12), .HALF_BIT_CYCLES(4), .PAUSE_BITS(3), .PARITY_ODD(1'b0)) dut_a (
        .clk_in(clk), .rst(rst_n), .tx_valid(valid[0]), .tx_data(data[0]), .tx_abort(abort[0]),
        .tx_ready(ready[0]), .code(code[0]), .busy(busy[0]), .frame_done(done[0])
    );
    man_tx_frame #(.PAYLOAD_W(12), .HALF_BIT_CYCLES(2), .PAUSE_BITS(1), .PARITY_ODD(1'b1)) dut_b (
        .clk_in(clk), .rst(rst_n), .tx_valid(valid[1]), .tx_data(data[1]), .tx_abort(abort[1]),
        .tx_ready(ready[1]), .code(code[1]), .busy(busy[1]), .frame_done(done[1])
    );
    man_tx_frame #(.PAYLOAD_W(12), .HALF_BIT_CYCLES(1), .PAUSE_BITS(0), .PARITY_ODD(1'b0)) dut_c (
        .clk_in(clk), .rst(rst_n), .tx_valid(valid[2]), .tx_data(data[2]), .tx_abort(abort[2]),
        .tx_ready(ready[2]), .code(code[2]), .busy(busy[2]), .frame_done(done[2])
    );

    function automatic int h_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 2 : 1;
    endfunction
    function automatic int p_of(input int d);
        return (d == 0) ? 3 : (d == 1) ? 1 : 0;
    endfunction
    function automatic int odd_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    // Half-bit sequence of a frame, first half-bit in bit 27.
    function automatic logic [27:0] ref_hb(input int d, input logic [11:0] x);
        logic [13:0] w;
        logic [27:0] r;
        logic        pb;
        pb = ((($countones(x) % 2) == 1) != (odd_of(d) == 1));
        w  = {x, pb, 1'b1};
        for (int i = 0; i < 14; i++) begin
            r[27-2*i] = ~w[13-i];
            r[26-2*i] = w[13-i];
        end
        return r;
    endfunction

    task automatic chk(input string name, input int d, input int t, input logic act,
                       input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut=%0d t=%0d got=%b want=%b", name, d, t, act, exp);
        end
    endtask

    // Call just after a negedge with ready[d]=1; returns at the negedge where ready is back.
    task automatic run_frame(input int d, input logic [11:0] x, input logic [27:0] hb,
                             input int abort_a, input bit keep_valid, input logic [11:0] x_next);
        int   h;
        int   p;
        int   e;
        logic ec, ef, eb;
        h = h_of(d);
        p = p_of(d);
        e = (abort_a > 0) ? abort_a : 28 * h;
        valid[d] = 1'b1;
        data[d]  = x;
        for (int t = 1; t <= e + 2 * p * h + 1; t++) begin
            @(negedge clk);
            ec = (t <= e) ? hb[27 - (t - 1) / h] : 1'b1;
            ef = (t == e + 1) && (abort_a == 0);
            eb = (t <= e + 2 * p * h);
            chk("code", d, t, code[d], ec);
            chk("frame_done", d, t, done[d], ef);
            chk("busy", d, t, busy[d], eb);
            chk("tx_ready", d, t, ready[d], ~eb);
            if (t == 1 && !keep_valid) valid[d] = 1'b0;
            if (t == 2) data[d] = x_next;
            if (abort_a > 0) abort[d] = (t == abort_a);
        end
    endtask

    typedef struct {
        int          d;
        logic [11:0] x;
        logic [27:0] hb;
        int          abort_hb;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [27:0] hb;
        int          d;
        int          a;
        logic [11:0] x;

        tbl[0] = '{0, 12'hA5C, 28'h66995A9, -1};
        tbl[1] = '{1, 12'h001, {22'h2AAAAA, 6'b011001}, -1};
        tbl[2] = '{1, 12'h000, {24'hAAAAAA, 4'b0101}, -1};
        tbl[3] = '{2, 12'hFFF, {24'h555555, 4'b1001}, -1};
        tbl[4] = '{0, 12'hA5C, 28'h66995A9, 9};

        rst_n = 1'b0;
        valid = '0;
        abort = '0;
        for (int i = 0; i < 3; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_code", i, 0, code[i], 1'b1);
            chk("rst_ready", i, 0, ready[i], 1'b1);
            chk("rst_busy", i, 0, busy[i], 1'b0);
            chk("rst_done", i, 0, done[i], 1'b0);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("idle_code", i, t, code[i], 1'b1);
                chk("idle_ready", i, t, ready[i], 1'b1);
                chk("idle_busy", i, t, busy[i], 1'b0);
            end
        end

        for (int i = 0; i < 5; i++) begin
            a = (tbl[i].abort_hb >= 0) ? tbl[i].abort_hb * h_of(tbl[i].d) + 1 : 0;
            run_frame(tbl[i].d, tbl[i].x, tbl[i].hb, a, 1'b0, 12'(~tbl[i].x));
        end

        // Back-to-back with tx_valid held and tx_data changed under the first frame.
        run_frame(0, 12'h3C9, ref_hb(0, 12'h3C9), 0, 1'b1, 12'h5A6);
        run_frame(0, 12'h5A6, ref_hb(0, 12'h5A6), 0, 1'b0, 12'h000);
        run_frame(2, 12'h123, ref_hb(2, 12'h123), 0, 1'b1, 12'hE0F);
        run_frame(2, 12'hE0F, ref_hb(2, 12'hE0F), 0, 1'b1, 12'h7B4);
        run_frame(2, 12'h7B4, ref_hb(2, 12'h7B4), 0, 1'b0, 12'h000);

        // Reset mid-frame: code must return high without waiting for a clock edge.
        hb = ref_hb(0, 12'hA5C);
        valid[0] = 1'b1;
        data[0]  = 12'hA5C;
        @(negedge clk);
        chk("mid_code", 0, 1, code[0], hb[27]);
        valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_code", 0, 0, code[0], 1'b1);
        chk("async_busy", 0, 0, busy[0], 1'b0);
        chk("async_ready", 0, 0, ready[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_ready", 0, 0, ready[0], 1'b1);
        chk("restart_code", 0, 0, code[0], 1'b1);
        run_frame(0, 12'hA5C, hb, 0, 1'b0, 12'h000);

        repeat (24) begin
            d = $urandom_range(0, 2);
            x = 12'($urandom);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 28 * h_of(d)) : 0;
            run_frame(d, x, ref_hb(d, x), a, 1'b0, 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/man_tx_frame.md
# man_tx_frame

Parametrised Manchester frame transmitter for the AS-Interface master path. It replaces the fixed 14-bit encoder, which used a separate 3 µs clock and a toggle-flag trigger. The block runs on a single system clock with an internal half-bit divider, and takes payloads through a valid/ready handshake. It appends a configurable parity bit and a stop bit, drives the Manchester line MSB first, and enforces a configurable inter-frame pause. It supports abort. It sits between the request formatter and the line driver.

## Interface
- PAYLOAD_W, 12: payload bits per frame (≥1); frame length N = PAYLOAD_W + 2 bits.
- HALF_BIT_CYCLES, 150: clk_in cycles per Manchester half-bit (≥1); 150 at 50 MHz = 3 µs.
- PAUSE_BITS, 3: idle bit times forced after every frame or abort (≥0).
- PARITY_ODD, 0: 0 = even parity (payload+PB has an even number of ones), 1 = odd.
- clk_in, input, 1: system clock, all logic on rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- tx_valid, input, 1: tx_data holds a frame request.
- tx_data, input, PAYLOAD_W: payload, bit PAYLOAD_W-1 transmitted first.
- tx_abort, input, 1: terminate the current frame.
- tx_ready, output, 1: block accepts a request this cycle.
- code, output, 1: Manchester line; idle level 1.
- busy, output, 1: high in SEND or PAUSE.
- frame_done, output, 1: one-cycle pulse on completion of a full frame.

## Operation
- Reset values (asserted asynchronously): code=1, tx_ready=1, busy=0, frame_done=0, state=IDLE, all counters 0.
- Frame word = {tx_data, PB, 1'b1}. PB = ^tx_data, XOR-ed with PARITY_ODD. The word is latched at acceptance; later tx_data changes have no effect.
- Bit encoding, first half then second half: 1 → 0,1; 0 → 1,0. There are 2N half-bits per frame.
- A shift register of 2N half-bits is loaded at acceptance, MSB first. A divider counts 0..HALF_BIT_CYCLES-1, and each wrap advances one half-bit.
- IDLE: tx_ready=1, code=1. If tx_valid=1 on an edge, the request is accepted, the word is latched and the block moves to SEND. tx_abort is ignored in IDLE.
- SEND: tx_ready=0, busy=1. code = current half-bit. After half-bit 2N-1 completes:
  - frame_done=1 for one cycle and code=1.
  - Go to PAUSE, or to IDLE if PAUSE_BITS=0.
- PAUSE: code=1, tx_ready=0, busy=1 for PAUSE_BITS×2×HALF_BIT_CYCLES cycles, then IDLE.
- Abort: tx_abort=1 on any edge in SEND gives code=1 from the next cycle and no frame_done. The block enters PAUSE with the full count, or IDLE if PAUSE_BITS=0. tx_abort in PAUSE is ignored; the pause is not restarted.
- tx_valid while not in IDLE is not accepted and not queued.
- Reset mid-frame: code returns to 1 immediately (asynchronously), and the frame is lost.

## Timing
- Acceptance on edge k: code carries half-bit 0 from edge k+1 to k+HALF_BIT_CYCLES. Half-bit j occupies edges k+1+j·H through k+(j+1)·H, where H = HALF_BIT_CYCLES.
- The frame occupies exactly 2N·H cycles. The frame_done pulse and code=1 appear at edge k+1+2N·H.
- tx_ready rises at edge k+1+2N·H+2·PAUSE_BITS·H. The earliest next acceptance is on that edge.
- Bit period is 2H cycles; there are no gaps between bits within a frame.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle: hold rst=0 and release. Required: code=1, tx_ready=1, busy=0 for 100 cycles with tx_valid=0.
- Basic frame: PAYLOAD_W=12, H=4, PAUSE_BITS=3, tx_data=12'hA5C.
  - PB=0, and the word is 1010_0101_1100_0_1.
  - code shows half-bits 01 10 01 10 10 01 10 01 01 01 10 10 10 01, each held 4 cycles, 112 cycles total.
  - frame_done pulses at cycle 113; tx_ready rises 24 cycles later.
- Odd parity: PARITY_ODD=1, tx_data=12'h001 → PB=0, so the last two bits are 0,1 and the final half-bits are 10 01. Also tx_data=12'h000 → PB=1.
- Back-to-back: tx_valid held high with two payloads. The second is accepted exactly on the tx_ready rising edge; a tx_data change mid-frame does not alter the transmitted bits.
- Abort: tx_abort pulsed at half-bit 9. Required: code=1 from the next cycle, no frame_done, busy for 24 more cycles, then tx_ready=1.
- Corners:
  - H=1, PAUSE_BITS=0: back-to-back frames with no idle cycle between them.
  - rst asserted mid-frame: code=1 asynchronously, then a clean restart with tx_ready=1.
